// File: rtl/cache_refill_ctrl.sv
// Miss handler for the 2-way data cache: stalls the CPU, fetches a line word by word
// from memory into the victim way chosen by a per-set LRU bit, then commits the tag.
module cache_refill_ctrl #(
  parameter int NUM_SETS    = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int SET_BITS    = 4,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_valid,
  input  logic [31:0]            miss_addr,
  input  logic                   access_valid,
  input  logic [SET_BITS-1:0]    access_set,
  input  logic                   access_way,
  output logic                   stall,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ready,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata,
  output logic                   fill_en,
  output logic [SET_BITS-1:0]    fill_set,
  output logic                   fill_way,
  output logic [OFFSET_BITS-1:0] fill_word,
  output logic [31:0]            fill_data,
  output logic                   fill_commit,
  output logic [TAG_BITS-1:0]    fill_tag,
  output logic                   done
);

  localparam int LINE_BITS = 30 - OFFSET_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [SET_BITS-1:0]    set_q, set_d;
  logic [TAG_BITS-1:0]    tag_q, tag_d;
  logic [LINE_BITS-1:0]   line_q, line_d;
  logic                   victim_q, victim_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic [NUM_SETS-1:0]    lru_q, lru_d;

  logic [SET_BITS-1:0]    miss_set;
  logic                   last_word;
  logic                   unused_addr_bits;

  assign miss_set  = miss_addr[2+OFFSET_BITS +: SET_BITS];
  assign last_word = (cnt_q == OFFSET_BITS'(BLOCK_WORDS - 1));
  // Refills always start at word 0, so the byte and word offsets of the miss are not needed.
  assign unused_addr_bits = ^miss_addr[1+OFFSET_BITS:0];

  always_comb begin
    state_d     = state_q;
    set_d       = set_q;
    tag_d       = tag_q;
    line_d      = line_q;
    victim_d    = victim_q;
    cnt_d       = cnt_q;
    lru_d       = lru_q;
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    fill_en     = 1'b0;
    fill_data   = '0;
    fill_commit = 1'b0;
    fill_set    = '0;
    fill_way    = 1'b0;
    fill_word   = '0;
    fill_tag    = '0;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        stall = miss_valid;
        if (access_valid) begin
          lru_d[access_set] = ~access_way;
        end
        if (miss_valid) begin
          set_d    = miss_set;
          tag_d    = miss_addr[31 -: TAG_BITS];
          line_d   = miss_addr[31 -: LINE_BITS];
          victim_d = lru_q[miss_set];
          cnt_d    = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {line_q, cnt_q, 2'b00};
        if (mem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          fill_en   = 1'b1;
          fill_data = mem_rdata;
          if (last_word) begin
            fill_commit   = 1'b1;
            lru_d[set_q]  = ~victim_q;
            state_d       = S_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) begin
      fill_set  = set_q;
      fill_way  = victim_q;
      fill_word = cnt_q;
      fill_tag  = tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      set_q    <= '0;
      tag_q    <= '0;
      line_q   <= '0;
      victim_q <= 1'b0;
      cnt_q    <= '0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      set_q    <= set_d;
      tag_q    <= tag_d;
      line_q   <= line_d;
      victim_q <= victim_d;
      cnt_q    <= cnt_d;
      lru_q    <= lru_d;
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: per-cycle vector table plus a hand-driven
// refill with variable memory latency.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        access_valid;
  logic [3:0]  access_set;
  logic        access_way;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        fill_en;
  logic [3:0]  fill_set;
  logic        fill_way;
  logic [1:0]  fill_word;
  logic [31:0] fill_data;
  logic        fill_commit;
  logic [23:0] fill_tag;
  logic        done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl #(
    .NUM_SETS   (16),
    .BLOCK_WORDS(4),
    .SET_BITS   (4),
    .OFFSET_BITS(2),
    .TAG_BITS   (24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .miss_valid  (miss_valid),
    .miss_addr   (miss_addr),
    .access_valid(access_valid),
    .access_set  (access_set),
    .access_way  (access_way),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .fill_en     (fill_en),
    .fill_set    (fill_set),
    .fill_way    (fill_way),
    .fill_word   (fill_word),
    .fill_data   (fill_data),
    .fill_commit (fill_commit),
    .fill_tag    (fill_tag),
    .done        (done)
  );

  typedef struct {
    logic        rst, mv;
    logic [31:0] ma;
    logic        av;
    logic [3:0]  as;
    logic        aw, rdy, rv;
    logic [31:0] rd;
    logic        st, rq;
    logic [31:0] ra;
    logic        fe;
    logic [3:0]  fs;
    logic        fw;
    logic [1:0]  fwd;
    logic [31:0] fd;
    logic        fc;
    logic [23:0] ft;
    logic        dn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input int r, input int mv, input logic [31:0] ma, input int av, input int as, input int aw,
    input int rdy, input int rv, input logic [31:0] rd,
    input int st, input int rq, input logic [31:0] ra, input int fe, input int fs, input int fw,
    input int fwd, input logic [31:0] fd, input int fc, input logic [31:0] ft, input int dn);
    vec_t v;
    v.rst = 1'(r);   v.mv = 1'(mv);  v.ma = ma;      v.av = 1'(av);
    v.as  = 4'(as);  v.aw = 1'(aw);  v.rdy = 1'(rdy); v.rv = 1'(rv);
    v.rd  = rd;      v.st = 1'(st);  v.rq = 1'(rq);   v.ra = ra;
    v.fe  = 1'(fe);  v.fs = 4'(fs);  v.fw = 1'(fw);   v.fwd = 2'(fwd);
    v.fd  = fd;      v.fc = 1'(fc);  v.ft = ft[23:0]; v.dn = 1'(dn);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    rst = 1'b0; miss_valid = 1'b0; miss_addr = '0; access_valid = 1'b0;
    access_set = '0; access_way = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic build_table();
    // Refill 1: load miss 0x1234, memory ready at once, rvalid one cycle later.
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,      0,0,0,      0,0,0,0,0,    0,0,   0));
    vecs.push_back(mk(0,1,'h1234,0,0,0, 1,0,0, 1,0,0,      0,0,0,0,0,    0,0,   0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,      1,1,'h1230, 0,3,0,0,0,    0,'h12,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,'hA0,   1,0,0,      1,3,0,0,'hA0, 0,'h12,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,      1,1,'h1234, 0,3,0,1,0,    0,'h12,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,'hA1,   1,0,0,      1,3,0,1,'hA1, 0,'h12,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,      1,1,'h1238, 0,3,0,2,0,    0,'h12,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,'hA2,   1,0,0,      1,3,0,2,'hA2, 0,'h12,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,      1,1,'h123C, 0,3,0,3,0,    0,'h12,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,'hA3,   1,0,0,      1,3,0,3,'hA3, 1,'h12,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,      0,0,0,      0,3,0,3,0,    0,'h12,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,'hDEAD, 0,0,0,      0,0,0,0,0,    0,0,   0));
    // Refill 2: miss 0x5638 held high throughout, ready low 3 cycles, one extra wait cycle.
    vecs.push_back(mk(0,1,'h5638,0,0,0, 0,0,0, 1,0,0,      0,0,0,0,0,    0,0,   0));
    vecs.push_back(mk(0,1,'h5638,0,0,0, 0,0,0, 1,1,'h5630, 0,3,1,0,0,    0,'h56,0));
    vecs.push_back(mk(0,1,'h5638,0,0,0, 0,0,0, 1,1,'h5630, 0,3,1,0,0,    0,'h56,0));
    vecs.push_back(mk(0,1,'h5638,0,0,0, 0,0,0, 1,1,'h5630, 0,3,1,0,0,    0,'h56,0));
    vecs.push_back(mk(0,1,'h5638,0,0,0, 1,0,0, 1,1,'h5630, 0,3,1,0,0,    0,'h56,0));
    vecs.push_back(mk(0,1,'h5638,0,0,0, 0,0,0, 1,0,0,      0,3,1,0,0,    0,'h56,0));
    vecs.push_back(mk(0,1,'h5638,0,0,0, 0,1,'hB0, 1,0,0,   1,3,1,0,'hB0, 0,'h56,0));
    vecs.push_back(mk(0,1,'h5638,0,0,0, 1,0,0, 1,1,'h5634, 0,3,1,1,0,    0,'h56,0));
    vecs.push_back(mk(0,1,'h5638,0,0,0, 0,1,'hB1, 1,0,0,   1,3,1,1,'hB1, 0,'h56,0));
    vecs.push_back(mk(0,1,'h5638,0,0,0, 1,0,0, 1,1,'h5638, 0,3,1,2,0,    0,'h56,0));
    vecs.push_back(mk(0,1,'h5638,0,0,0, 0,1,'hB2, 1,0,0,   1,3,1,2,'hB2, 0,'h56,0));
    vecs.push_back(mk(0,1,'h5638,0,0,0, 1,0,0, 1,1,'h563C, 0,3,1,3,0,    0,'h56,0));
    vecs.push_back(mk(0,1,'h5638,0,0,0, 0,1,'hB3, 1,0,0,   1,3,1,3,'hB3, 1,'h56,0));
    vecs.push_back(mk(0,1,'h5638,0,0,0, 0,0,0, 0,0,0,      0,3,1,3,0,    0,'h56,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,      0,0,0,      0,0,0,0,0,    0,0,   0));
    // Hit set 7 way 0 (lru[7]=1), then refill 3 to set 3 picks way 0; reset in WAIT after 2 words.
    vecs.push_back(mk(0,0,0,1,7,0, 0,0,0,      0,0,0,      0,0,0,0,0,    0,0,   0));
    vecs.push_back(mk(0,1,'h9930,0,0,0, 0,0,0, 1,0,0,      0,0,0,0,0,    0,0,   0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,      1,1,'h9930, 0,3,0,0,0,    0,'h99,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,'hC0,   1,0,0,      1,3,0,0,'hC0, 0,'h99,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,      1,1,'h9934, 0,3,0,1,0,    0,'h99,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,'hC1,   1,0,0,      1,3,0,1,'hC1, 0,'h99,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,      1,1,'h9938, 0,3,0,2,0,    0,'h99,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,      1,0,0,      0,3,0,2,0,    0,'h99,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,1,'hDEAD, 0,0,0,      0,0,0,0,0,    0,0,   0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,      0,0,0,      0,0,0,0,0,    0,0,   0));
    // Reset cleared lru[7]: a miss to set 7 now picks way 0; reset again from REQ.
    vecs.push_back(mk(0,1,'h0070,0,0,0, 0,0,0, 1,0,0,      0,0,0,0,0,    0,0,   0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,      1,1,'h0070, 0,7,0,0,0,    0,0,   0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,      1,1,'h0070, 0,7,0,0,0,    0,0,   0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,      0,0,0,      0,0,0,0,0,    0,0,   0));
  endtask

  initial begin
    int unsigned words, dones, pending, delay;

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    build_table();

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;  miss_valid = vecs[i].mv; miss_addr = vecs[i].ma;
      access_valid = vecs[i].av; access_set = vecs[i].as; access_way = vecs[i].aw;
      mem_ready = vecs[i].rdy; mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rd;
      #2;
      chk($sformatf("v%0d stall", i),       32'(stall),       32'(vecs[i].st));
      chk($sformatf("v%0d mem_req", i),     32'(mem_req),     32'(vecs[i].rq));
      chk($sformatf("v%0d mem_addr", i),    mem_addr,         vecs[i].ra);
      chk($sformatf("v%0d fill_en", i),     32'(fill_en),     32'(vecs[i].fe));
      chk($sformatf("v%0d fill_set", i),    32'(fill_set),    32'(vecs[i].fs));
      chk($sformatf("v%0d fill_way", i),    32'(fill_way),    32'(vecs[i].fw));
      chk($sformatf("v%0d fill_word", i),   32'(fill_word),   32'(vecs[i].fwd));
      chk($sformatf("v%0d fill_data", i),   fill_data,        vecs[i].fd);
      chk($sformatf("v%0d fill_commit", i), 32'(fill_commit), 32'(vecs[i].fc));
      chk($sformatf("v%0d fill_tag", i),    32'(fill_tag),    32'(vecs[i].ft));
      chk($sformatf("v%0d done", i),        32'(done),        32'(vecs[i].dn));
    end

    // Hit set 3 way 0 makes way 1 the victim; refill 0xA03C with ready every third
    // cycle and rvalid two cycles after each accepted request.
    @(negedge clk);
    drive_idle();
    access_valid = 1'b1; access_set = 4'd3; access_way = 1'b0;
    @(negedge clk);
    drive_idle();
    miss_valid = 1'b1; miss_addr = 32'h0000_A03C;
    #2;
    chk("seq miss stall", 32'(stall), 32'd1);
    words = 0; dones = 0; pending = 0; delay = 0;
    for (int unsigned cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      drive_idle();
      mem_ready  = ((cyc % 3) == 2);
      mem_rvalid = (pending != 0) && (delay == 0);
      mem_rdata  = 32'hC0 + 32'(words);
      #2;
      if (mem_req && mem_ready) begin
        chk("seq mem_addr", mem_addr, 32'h0000_A030 + 32'(4 * words));
        chk("seq fill_way", 32'(fill_way), 32'd1);
        chk("seq fill_tag", 32'(fill_tag), 32'h0000_00A0);
      end
      if (fill_en) begin
        chk("seq fill_word", 32'(fill_word), 32'(words));
        chk("seq fill_data", fill_data, 32'hC0 + 32'(words));
        chk("seq fill_commit", 32'(fill_commit), 32'(words == 3));
        words++;
      end
      if (done) dones++;
      if (mem_rvalid) pending = 0;
      else if (pending != 0 && delay > 0) delay--;
      if (mem_req && mem_ready) begin
        pending = 1;
        delay   = 1;
      end
    end
    chk("seq words filled", 32'(words), 32'd4);
    chk("seq done pulses", 32'(dones), 32'd1);
    chk("seq idle stall", 32'(stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss handler sitting directly beside the 2-way data cache, between the cache and main memory.
- On a cache lookup miss it does the following:
  - stalls the CPU;
  - picks a victim way with a per-set LRU bit;
  - fetches the 4-word block from memory one word at a time over a req/ready + rvalid handshake;
  - streams each word into the cache fill port;
  - commits the tag and valid bit on the last word.
- Also tracks LRU state from cache hits.

Parameters:
- NUM_SETS, 16, number of cache sets (one LRU bit each).
- BLOCK_WORDS, 4, 32-bit words per line.
- SET_BITS, 4, set index width (log2 NUM_SETS).
- OFFSET_BITS, 2, word-in-line width (log2 BLOCK_WORDS).
- TAG_BITS, 24, tag width = 30 - SET_BITS - OFFSET_BITS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- miss_valid  in  1  cache lookup this cycle missed (load or store)
- miss_addr  in  32  byte address of the missing access
- access_valid  in  1  cache lookup this cycle was a hit
- access_set  in  SET_BITS  set index of the hit
- access_way  in  1  way that hit
- stall  out  1  CPU must hold its current access
- mem_req  out  1  word read request to memory
- mem_addr  out  32  word-aligned byte address of the request
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data returned this cycle
- mem_rdata  in  32  read data
- fill_en  out  1  write fill_data into data_array[fill_set][fill_way][fill_word]
- fill_set  out  SET_BITS  set being filled
- fill_way  out  1  victim way
- fill_word  out  OFFSET_BITS  word index within line
- fill_data  out  32  word to write
- fill_commit  out  1  write fill_tag and set valid for [fill_set][fill_way]
- fill_tag  out  TAG_BITS  tag of the new line
- done  out  1  one-cycle pulse: refill complete

Behaviour:
- Address split is on the word address addr[31:2]:
  - word offset = addr[3:2];
  - set = addr[7:4];
  - tag = addr[31:8];
  - line base = {addr[31:4], 4'b0}.
- FSM states: IDLE, REQ, WAIT, DONE. Registers: captured set, captured tag, line base, victim way, word counter cnt (OFFSET_BITS), LRU bit per set.
- IDLE:
  - When miss_valid=1, capture set/tag/base, set victim = lru[set] and cnt = 0, then go to REQ.
  - mem_rvalid is ignored in IDLE.
- REQ:
  - mem_req=1, mem_addr = base + 4*cnt.
  - On mem_ready=1, go to WAIT. Otherwise hold mem_req and mem_addr stable.
- WAIT:
  - mem_req=0.
  - On mem_rvalid=1, in the same cycle drive fill_en=1, fill_word=cnt, fill_data=mem_rdata.
  - If cnt == BLOCK_WORDS-1: also drive fill_commit=1, set lru[set] <= ~victim, go to DONE.
  - Else: cnt <= cnt+1, go to REQ.
- DONE:
  - done=1 for one cycle, then go to IDLE.
  - miss_valid is ignored (the retried access hits the new line).
- Outputs:
  - stall = (state==REQ) || (state==WAIT) || (state==IDLE && miss_valid).
  - stall is 0 in DONE, so the CPU retries that cycle.
  - fill_set, fill_way and fill_tag show the captured values whenever state != IDLE.
- Only one request is outstanding at a time. Words are fetched in order 0..3; there is no critical-word-first.
- Minimum latency (mem_ready=1 in REQ, rvalid one cycle later):
  - miss seen at T0;
  - words land at T2, T4, T6, T8;
  - commit at T8;
  - DONE/done at T9;
  - the retry hits at T9.
- LRU:
  - lru[s] = way to evict next.
  - When access_valid=1 and state==IDLE, set lru[access_set] <= ~access_way.
  - access_valid is ignored in other states.
  - Commit and access never coincide.
- Store misses follow the same flow. The store itself completes on the retried hit.
- Reset (any state, including mid-refill):
  - state=IDLE, cnt=0, all lru=0;
  - stall, mem_req, fill_en, fill_commit and done all 0 on the next cycle;
  - a late mem_rvalid after reset is ignored;
  - the partially filled line stays invalid because commit never fired.
- All other outputs reset to 0.

Test Plan:
- Load miss at 0x0000_1234, memory ready immediately, rdata = 0xA0..0xA3:
  - mem_addr sequence is 0x1230, 0x1234, 0x1238, 0x123C;
  - fill_set=3, fill_way=0, fill_tag=0x000012;
  - fill_commit at T8, done at T9;
  - lru[3]=1 afterwards.
- Second miss to set 3 at 0x0000_5638 (tag 0x000056): victim way 1, base 0x5630, lru[3] returns to 0 after commit.
- Hit in set 3 way 0 (access_valid=1) in IDLE: lru[3]=1. The next miss to set 3 evicts way 1.
- mem_ready held low 3 cycles in REQ: mem_req and mem_addr stay stable, stall stays 1, no fill_en occurs.
- rst asserted in WAIT after 2 words: next cycle state is IDLE with stall=0 and no commit; a stray mem_rvalid produces no fill_en; all lru=0.
- miss_valid held high through DONE: no new refill starts; done pulses once.
